if_id_stage: RTL and testbench

//  IF/ID pipeline latch plus RAW hazard detector, directly downstream of fetch.

---
 rtl/if_id_stage_pkg.sv | 39 +++
 rtl/if_id_stage_hazard_detect.sv | 27 ++
 rtl/register.sv | 18 +
 rtl/if_id_stage.sv | 108 ++++++++++
 tb/tb_if_id_stage.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared opcodes, bubble encoding and FSM states for the IF/ID stage.
package if_id_stage_pkg;

   localparam int unsigned WIDTH     = 16;
   localparam int unsigned REG_BITS  = 3;
   localparam int unsigned OPC_BITS  = 5;
   localparam int unsigned CNT_BITS  = 16;

   localparam logic [WIDTH-1:0] NOP_INSTR = 16'h0800;

   localparam logic [OPC_BITS-1:0] OP_HALT   = 5'b00000;
   localparam logic [OPC_BITS-1:0] OP_NOP    = 5'b00001;
   localparam logic [OPC_BITS-1:0] OP_J      = 5'b00100;
   localparam logic [OPC_BITS-1:0] OP_JAL    = 5'b00110;
   localparam logic [OPC_BITS-1:0] OP_LBI    = 5'b11000;
   localparam logic [OPC_BITS-1:0] OP_ST     = 5'b10000;
   localparam logic [OPC_BITS-1:0] OP_STU    = 5'b10011;
   localparam logic [OPC_BITS-1:0] OP_ADDSUB = 5'b11011;
   localparam logic [OPC_BITS-1:0] OP_LOGIC  = 5'b11010;
   localparam logic [2:0]          OP_RGRP   = 3'b111;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STALL  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   // Rs is read by everything except halt/nop, direct jumps and LBI.
   function automatic logic uses_rs(input logic [OPC_BITS-1:0] op);
      return !(op == OP_HALT || op == OP_NOP || op == OP_J ||
               op == OP_JAL  || op == OP_LBI);
   endfunction

   function automatic logic uses_rt(input logic [OPC_BITS-1:0] op);
      return (op == OP_ADDSUB) || (op == OP_LOGIC) || (op[4:2] == OP_RGRP) ||
             (op == OP_ST) || (op == OP_STU);
   endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// RAW hazard check of the latched instruction's sources against ID/EX and EX/MEM dests.
module if_id_stage_hazard_detect
   import if_id_stage_pkg::*;
(
   input  logic [OPC_BITS-1:0] i_opcode,
   input  logic [REG_BITS-1:0] i_rs,
   input  logic [REG_BITS-1:0] i_rt,
   input  logic                i_valid,
   input  logic [REG_BITS-1:0] i_idex_rd,
   input  logic                i_idex_regwrite,
   input  logic [REG_BITS-1:0] i_exmem_rd,
   input  logic                i_exmem_regwrite,
   output logic                o_hazard_c
);

   logic w_rs_hit;
   logic w_rt_hit;

   assign w_rs_hit = (i_idex_regwrite  && (i_idex_rd  == i_rs)) ||
                     (i_exmem_regwrite && (i_exmem_rd == i_rs));
   assign w_rt_hit = (i_idex_regwrite  && (i_idex_rd  == i_rt)) ||
                     (i_exmem_regwrite && (i_exmem_rd == i_rt));

   assign o_hazard_c = i_valid && ((uses_rs(i_opcode) && w_rs_hit) ||
                                   (uses_rt(i_opcode) && w_rt_hit));

endmodule

// File: rtl/register.sv
// Generic enabled register with synchronous active-high reset.
module register #(
   parameter int unsigned   W       = 16,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_we,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   always_ff @(posedge clk) begin
      if (rst)       o_q <= RST_VAL;
      else if (i_we) o_q <= i_d;
   end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline latch with RAW stall, redirect squash and HALT freeze.
module if_id_stage
   import if_id_stage_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    instr_in,
   input  logic [WIDTH-1:0]    pc_next_in,
   input  logic [WIDTH-1:0]    pc_curr_in,
   input  logic                flush,
   input  logic [REG_BITS-1:0] idex_rd,
   input  logic                idex_regwrite,
   input  logic [REG_BITS-1:0] exmem_rd,
   input  logic                exmem_regwrite,
   output logic [WIDTH-1:0]    instr_out,
   output logic [WIDTH-1:0]    pc_next_out,
   output logic [WIDTH-1:0]    pc_curr_out,
   output logic                valid_out,
   output logic                id_bubble,
   output logic                stall_fetch,
   output logic                halted,
   output logic [CNT_BITS-1:0] stall_count
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_hazard;
   logic                w_halt_entry;
   logic                w_hold;
   logic [WIDTH-1:0]    w_instr_d;
   logic [CNT_BITS-1:0] r_stall_count;

   if_id_stage_hazard_detect u_hazard (
      .i_opcode         (instr_out[15:11]),
      .i_rs             (instr_out[10:8]),
      .i_rt             (instr_out[7:5]),
      .i_valid          (valid_out),
      .i_idex_rd        (idex_rd),
      .i_idex_regwrite  (idex_regwrite),
      .i_exmem_rd       (exmem_rd),
      .i_exmem_regwrite (exmem_regwrite),
      .o_hazard_c       (w_hazard)
   );

   assign w_halt_entry = valid_out && (instr_out[15:11] == OP_HALT);
   assign w_instr_d    = flush ? NOP_INSTR : instr_in;

   register #(.W(WIDTH), .RST_VAL(NOP_INSTR)) u_instr_q (
      .clk(clk), .rst(rst), .i_we(~w_hold), .i_d(w_instr_d), .o_q(instr_out)
   );
   register #(.W(WIDTH), .RST_VAL('0)) u_pc_next_q (
      .clk(clk), .rst(rst), .i_we(~w_hold), .i_d(pc_next_in), .o_q(pc_next_out)
   );
   register #(.W(WIDTH), .RST_VAL('0)) u_pc_curr_q (
      .clk(clk), .rst(rst), .i_we(~w_hold), .i_d(pc_curr_in), .o_q(pc_curr_out)
   );
   register #(.W(1), .RST_VAL(1'b0)) u_valid_q (
      .clk(clk), .rst(rst), .i_we(~w_hold), .i_d(~flush), .o_q(valid_out)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_RUN;
      else     r_state <= w_state_nxt;
   end

   // Flush beats hazard and halt entry; HALTED is left only through reset.
   always_comb begin
      w_state_nxt = r_state;
      w_hold      = 1'b0;
      stall_fetch = 1'b0;
      id_bubble   = 1'b0;
      case (r_state)
         ST_RUN, ST_STALL: begin
            if (flush) begin
               w_state_nxt = ST_RUN;
            end else if (w_hazard) begin
               w_hold      = 1'b1;
               stall_fetch = 1'b1;
               id_bubble   = 1'b1;
               w_state_nxt = ST_STALL;
            end else if (w_halt_entry) begin
               w_hold      = 1'b1;
               stall_fetch = 1'b1;
               w_state_nxt = ST_HALTED;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_HALTED: begin
            w_hold      = 1'b1;
            stall_fetch = 1'b1;
            id_bubble   = 1'b1;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_stall_count <= '0;
      else if (stall_fetch && (r_state != ST_HALTED) && (r_stall_count != '1))
         r_stall_count <= r_stall_count + CNT_BITS'(1);
   end

   assign stall_count = r_stall_count;
   assign halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with a per-cycle reference model and literal pins.
module tb_if_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr_in;
   logic [15:0] pc_curr_in;
   logic [15:0] pc_next_in;
   logic        flush;
   logic [2:0]  idex_rd;
   logic        idex_regwrite;
   logic [2:0]  exmem_rd;
   logic        exmem_regwrite;
   logic [15:0] instr_out;
   logic [15:0] pc_next_out;
   logic [15:0] pc_curr_out;
   logic        valid_out;
   logic        id_bubble;
   logic        stall_fetch;
   logic        halted;
   logic [15:0] stall_count;

   int n_vec = 0;
   int n_err = 0;
   bit check_en = 1'b0;

   // Reference model state
   logic [15:0] m_instr, m_pcn, m_pcc, m_count;
   bit          m_valid, m_halted;

   always #5 clk = ~clk;
   assign pc_next_in = pc_curr_in + 16'd2;

   if_id_stage dut (
      .clk(clk), .rst(rst), .instr_in(instr_in), .pc_next_in(pc_next_in),
      .pc_curr_in(pc_curr_in), .flush(flush), .idex_rd(idex_rd),
      .idex_regwrite(idex_regwrite), .exmem_rd(exmem_rd),
      .exmem_regwrite(exmem_regwrite), .instr_out(instr_out),
      .pc_next_out(pc_next_out), .pc_curr_out(pc_curr_out),
      .valid_out(valid_out), .id_bubble(id_bubble), .stall_fetch(stall_fetch),
      .halted(halted), .stall_count(stall_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit reads(input logic [15:0] ins, input logic [2:0] r);
      logic [4:0] op;
      bit rs_used, rt_used;
      op      = ins[15:11];
      rs_used = !(op inside {5'b00000, 5'b00001, 5'b00100, 5'b00110, 5'b11000});
      rt_used = (op inside {5'b11011, 5'b11010, 5'b10000, 5'b10011}) || (op[4:2] == 3'b111);
      return (rs_used && ins[10:8] == r) || (rt_used && ins[7:5] == r);
   endfunction

   function automatic bit m_haz();
      return m_valid && ((idex_regwrite && reads(m_instr, idex_rd)) ||
                         (exmem_regwrite && reads(m_instr, exmem_rd)));
   endfunction

   function automatic bit m_halt_issue();
      return m_valid && (m_instr[15:11] == 5'b00000);
   endfunction

   function automatic bit exp_stall();
      if (m_halted) return 1'b1;
      return !flush && (m_haz() || m_halt_issue());
   endfunction

   function automatic bit exp_bubble();
      if (m_halted) return 1'b1;
      return !flush && m_haz();
   endfunction

   // Model advance at each active edge
   always @(posedge clk) begin
      if (rst) begin
         m_instr = 16'h0800; m_pcn = '0; m_pcc = '0; m_valid = 0; m_halted = 0; m_count = '0;
      end else if (!m_halted) begin
         if (exp_stall() && m_count != 16'hFFFF) m_count = m_count + 16'd1;
         if (flush) begin
            m_instr = 16'h0800; m_valid = 0; m_pcn = pc_next_in; m_pcc = pc_curr_in;
         end else if (m_haz()) begin
         end else if (m_halt_issue()) begin
            m_halted = 1;
         end else begin
            m_instr = instr_in; m_valid = 1; m_pcn = pc_next_in; m_pcc = pc_curr_in;
         end
      end
   end

   // Compare process on the inactive edge
   always @(negedge clk) begin
      if (check_en) begin
         chk("instr_out",   32'(instr_out),   32'(m_instr));
         chk("pc_next_out", 32'(pc_next_out), 32'(m_pcn));
         chk("pc_curr_out", 32'(pc_curr_out), 32'(m_pcc));
         chk("valid_out",   32'(valid_out),   32'(m_valid));
         chk("halted",      32'(halted),      32'(m_halted));
         chk("stall_count", 32'(stall_count), 32'(m_count));
         chk("stall_fetch", 32'(stall_fetch), 32'(exp_stall()));
         chk("id_bubble",   32'(id_bubble),   32'(exp_bubble()));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic r, input logic [15:0] ins, input logic [15:0] pc,
                      input logic fl, input logic [2:0] ird, input logic irw,
                      input logic [2:0] erd, input logic erw);
      rst = r; instr_in = ins; pc_curr_in = pc; flush = fl;
      idex_rd = ird; idex_regwrite = irw; exmem_rd = erd; exmem_regwrite = erw;
   endtask

   initial begin
      m_instr = 16'h0800; m_pcn = '0; m_pcc = '0; m_valid = 0; m_halted = 0; m_count = '0;
      drv(1, 16'hDA64, 16'h0010, 0, 0, 0, 0, 0);
      step();
      check_en = 1'b1;
      step();
      chk("rst_instr",  32'(instr_out),   32'h0800);
      chk("rst_valid",  32'(valid_out),   32'h0);
      chk("rst_stall",  32'(stall_fetch), 32'h0);
      chk("rst_count",  32'(stall_count), 32'h0);
      chk("rst_halted", 32'(halted),      32'h0);

      // ADD r1 then consumer of r1, hazard via ID/EX then EX/MEM
      drv(0, 16'hDA64, 16'h0010, 0, 0, 0, 0, 0); step();
      chk("load_add", 32'(instr_out), 32'hDA64);
      chk("load_pcn", 32'(pc_next_out), 32'h0012);
      drv(0, 16'hD950, 16'h0012, 0, 0, 0, 0, 0); step();
      drv(0, 16'h4121, 16'h0014, 0, 1, 1, 0, 0); #1;
      chk("haz_idex_stall",  32'(stall_fetch), 32'h1);
      chk("haz_idex_bubble", 32'(id_bubble),   32'h1);
      step();
      chk("haz_hold", 32'(instr_out), 32'hD950);
      drv(0, 16'h4121, 16'h0014, 0, 1, 0, 1, 1); #1;
      chk("haz_exmem_stall", 32'(stall_fetch), 32'h1);
      step();
      drv(0, 16'h4121, 16'h0014, 0, 0, 0, 0, 0); step();
      chk("resume_instr", 32'(instr_out),   32'h4121);
      chk("resume_count", 32'(stall_count), 32'h2);

      // No stall: regwrite low, or different dest
      drv(0, 16'h4121, 16'h0016, 0, 1, 0, 0, 0); #1;
      chk("no_rw_stall", 32'(stall_fetch), 32'h0);
      step();
      drv(0, 16'h2104, 16'h0018, 0, 2, 1, 0, 0); #1;
      chk("other_rd_stall", 32'(stall_fetch), 32'h0);
      step();
      chk("load_j", 32'(instr_out), 32'h2104);

      // J ignores Rs field
      drv(0, 16'hD950, 16'h001A, 0, 1, 1, 0, 0); #1;
      chk("j_rs_stall", 32'(stall_fetch), 32'h0);
      step();

      // Flush during STALL
      drv(0, 16'hDA64, 16'h001C, 0, 1, 1, 0, 0); step();
      chk("in_stall", 32'(stall_fetch), 32'h1);
      drv(0, 16'hDA64, 16'h001C, 1, 1, 1, 0, 0); #1;
      chk("flush_stall", 32'(stall_fetch), 32'h0);
      step();
      chk("flush_instr", 32'(instr_out), 32'h0800);
      chk("flush_valid", 32'(valid_out), 32'h0);
      drv(0, 16'hDA64, 16'h001C, 0, 1, 1, 0, 0); #1;
      chk("post_flush_stall", 32'(stall_fetch), 32'h0);
      step();

      // HALT freeze
      drv(0, 16'h0000, 16'h001E, 0, 0, 0, 0, 0); step();
      drv(0, 16'hDA64, 16'h0020, 0, 0, 0, 0, 0); #1;
      chk("halt_entry_stall",  32'(stall_fetch), 32'h1);
      chk("halt_entry_bubble", 32'(id_bubble),   32'h0);
      step();
      for (int i = 0; i < 10; i++) begin
         drv(0, 16'(16'h1000 + i), 16'(16'h0030 + 2 * i), 0, 3'(i), 1, 3'(i + 1), 1);
         step();
         chk("halt_frozen", 32'(instr_out), 32'h0000);
         chk("halt_flag",   32'(halted),    32'h1);
      end
      drv(1, 16'hDA64, 16'h0040, 0, 0, 0, 0, 0); step();
      chk("halt_rst_halted", 32'(halted),    32'h0);
      chk("halt_rst_instr",  32'(instr_out), 32'h0800);

      // HALT with same-cycle flush never halts
      drv(0, 16'h0000, 16'h0042, 0, 0, 0, 0, 0); step();
      drv(0, 16'hDA64, 16'h0044, 1, 0, 0, 0, 0); step();
      chk("halt_flush_halted", 32'(halted),    32'h0);
      chk("halt_flush_instr",  32'(instr_out), 32'h0800);
      drv(0, 16'hDA64, 16'h0044, 0, 0, 0, 0, 0); step();
      chk("halt_flush_next", 32'(halted), 32'h0);

      // Counter saturation under a long stall
      drv(1, 16'h0800, 16'h0000, 0, 0, 0, 0, 0); step();
      drv(0, 16'hD950, 16'h0050, 0, 0, 0, 0, 0); step();
      drv(0, 16'h4121, 16'h0052, 0, 1, 1, 0, 0);
      for (int i = 0; i < 65540; i++) step();
      chk("sat_count", 32'(stall_count), 32'h0000FFFF);
      chk("sat_stall", 32'(stall_fetch), 32'h1);
      drv(1, 16'h0800, 16'h0000, 0, 0, 0, 0, 0); step();
      chk("sat_rst_count", 32'(stall_count), 32'h0);

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
